trim_frame_loader: RTL and testbench

- Upstream feeder for the trim DAC controller.
- Parses a framed byte stream from the UART decoder carrying 9 trim DAC codes and holds it in a shadow buffer.
- Verifies a checksum, then copies the buffer into the trim LUT over the LUT write port.
- Fires the single-cycle load strobe and locks out further commits while the DAC chain is still shifting.

---
 rtl/trim_pkg.sv | 25 ++
 rtl/trim_frame_buf.sv | 27 ++
 rtl/trim_frame_loader.sv | 146 ++++++++++++++
 tb/tb_trim_frame_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trim_pkg.sv
// ---------------------------------------------------------------------------
// trim_pkg: shared types and constants for the trim frame loader. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package trim_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_DATA = 3'd1,
    RX_CSUM = 3'd2,
    WAIT    = 3'd3,
    COMMIT  = 3'd4,
    TRIG    = 3'd5
  } state_t;

  localparam logic [7:0] HEADER         = 8'hC0;
  localparam int         N_TRIM_CH      = 9;
  localparam int         N_LUT_BYTES    = 2 * N_TRIM_CH;
  localparam int         HOLDOFF_CYCLES = 640;
  localparam int         TIMEOUT_CYCLES = 400000;

endpackage

`default_nettype wire

// File: rtl/trim_frame_buf.sv
// ---------------------------------------------------------------------------
// trim_frame_buf: 18x7 shadow register file, one write and one read port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trim_frame_buf (
  input  logic       clk40,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [6:0] wdata,
  input  logic [4:0] raddr,
  output logic [6:0] rdata
);
  import trim_pkg::*;

  logic [6:0] mem [N_LUT_BYTES];

  always_ff @(posedge clk40) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read index runs one past the last entry on the final commit cycle.
  assign rdata = (raddr < 5'(N_LUT_BYTES)) ? mem[raddr] : 7'd0;

endmodule

`default_nettype wire

// File: rtl/trim_frame_loader.sv
// ---------------------------------------------------------------------------
// trim_frame_loader: parses trim frames, verifies checksum, commits to the LUT
// and strobes the DAC load with a post-load holdoff. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trim_frame_loader #(
  parameter int TIMEOUT_CYCLES = trim_pkg::TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = trim_pkg::HOLDOFF_CYCLES
) (
  input  logic       clk40,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] lut_data,
  output logic [4:0] lut_addr,
  output logic       lut_we,
  output logic       load_dacs,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] err_count
);
  import trim_pkg::*;

  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         HLD_W    = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [4:0] LAST_IDX = 5'(N_LUT_BYTES - 1);

  state_t           state, state_nx;
  logic [4:0]       idx, idx_nx;
  logic [4:0]       cidx, cidx_nx;
  logic [6:0]       sum, sum_nx;
  logic [TMO_W-1:0] tmo, tmo_nx;
  logic [HLD_W-1:0] hold, hold_nx;
  logic             err_nx, buf_we, in_rx, is_hdr, is_ctrl, tmo_hit;
  logic [6:0]       buf_rdata;

  trim_frame_buf u_buf (
    .clk40 (clk40),
    .we    (buf_we),
    .waddr (idx),
    .wdata (rx_data[6:0]),
    .raddr (cidx_nx),
    .rdata (buf_rdata)
  );

  always_comb begin
    is_hdr   = rx_valid && (rx_data == HEADER);
    is_ctrl  = rx_valid && rx_data[7] && !is_hdr;
    in_rx    = (state == RX_DATA) || (state == RX_CSUM);
    tmo_hit  = in_rx && !rx_valid && (tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    state_nx = state;
    idx_nx   = idx;
    sum_nx   = sum;
    buf_we   = 1'b0;
    err_nx   = 1'b0;
    cidx_nx  = (state == COMMIT) ? cidx + 5'd1 : 5'd0;
    hold_nx  = (hold != '0) ? hold - HLD_W'(1) : hold;
    tmo_nx   = (in_rx && !rx_valid) ? tmo + TMO_W'(1) : '0;

    case (state)
      IDLE: begin
        if (is_hdr) begin
          state_nx = RX_DATA;
          idx_nx   = 5'd0;
          sum_nx   = 7'd0;
        end
      end
      RX_DATA, RX_CSUM: begin
        if (is_hdr) begin
          state_nx = RX_DATA;
          idx_nx   = 5'd0;
          sum_nx   = 7'd0;
        end else if (is_ctrl || tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (rx_valid && state == RX_DATA) begin
          buf_we = 1'b1;
          sum_nx = sum + rx_data[6:0];
          idx_nx = idx + 5'd1;
          if (idx == LAST_IDX) state_nx = RX_CSUM;
        end else if (rx_valid) begin
          if (sum + rx_data[6:0] == 7'd0) begin
            state_nx = (hold_nx == '0) ? COMMIT : WAIT;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      WAIT: begin
        err_nx = rx_valid;
        if (hold_nx == '0) state_nx = COMMIT;
      end
      COMMIT: begin
        err_nx = rx_valid;
        if (cidx == LAST_IDX) state_nx = TRIG;
      end
      TRIG: begin
        // Holdoff counts the cycles after the strobe in which no write may start.
        err_nx   = rx_valid;
        hold_nx  = HLD_W'(HOLDOFF_CYCLES - 1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      cidx      <= 5'd0;
      sum       <= 7'd0;
      tmo       <= '0;
      hold      <= '0;
      lut_data  <= 7'd0;
      lut_addr  <= 5'd0;
      lut_we    <= 1'b0;
      load_dacs <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cidx      <= cidx_nx;
      sum       <= sum_nx;
      tmo       <= tmo_nx;
      hold      <= hold_nx;
      lut_we    <= (state_nx == COMMIT);
      if (state_nx == COMMIT) begin
        lut_addr <= cidx_nx;
        lut_data <= buf_rdata;
      end
      load_dacs <= (state_nx == TRIG);
      busy      <= (state_nx == WAIT) || (state_nx == COMMIT) || (state_nx == TRIG)
                   || (hold_nx != '0) || (hold != '0);
      frame_err <= err_nx;
      if (err_nx && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trim_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_trim_frame_loader: directed and random frames against a timeline model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_trim_frame_loader;

  localparam int         TMO  = 1000;
  localparam int         HOLD = 640;
  localparam int         NB   = 18;
  localparam int         MAXC = 40000;
  localparam logic [7:0] HDR  = 8'hC0;

  logic       clk40 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [6:0] lut_data;
  logic [4:0] lut_addr;
  logic       lut_we, load_dacs, busy, frame_err;
  logic [7:0] err_count;

  trim_frame_loader #(.TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk40     (clk40),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .lut_data  (lut_data),
    .lut_addr  (lut_addr),
    .lut_we    (lut_we),
    .load_dacs (load_dacs),
    .busy      (busy),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #12 clk40 = ~clk40;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc + 1);
  endtask

  // Expected output timeline, indexed by the cycle in which the value is visible.
  bit       e_we   [MAXC];
  bit [4:0] e_addr [MAXC];
  bit [6:0] e_data [MAXC];
  bit       e_ld   [MAXC];
  bit       e_busy [MAXC];
  bit       e_err  [MAXC];

  bit       in_frame = 0;
  bit [6:0] pl[$];
  int       lastb = 0, acc = -1, ld = -1, free_at = 0, first = 0, s = 0;

  initial begin : model
    forever begin
      @(posedge clk40);
      cyc++;
      if (cyc >= MAXC - 800) begin
        $display("FAIL watchdog: got cycle %0d expected below %0d", cyc, MAXC - 800);
        $fatal(1);
      end
      if (rst) begin
        for (int k = cyc + 1; k < MAXC; k++) begin
          e_we[k] = 0; e_ld[k] = 0; e_busy[k] = 0; e_err[k] = 0;
        end
        in_frame = 0; pl.delete(); acc = -1; ld = -1; free_at = 0;
      end else if (acc >= 0 && cyc > acc && cyc <= ld) begin
        if (rx_valid) e_err[cyc+1] = 1;
      end else if (!in_frame) begin
        if (rx_valid && rx_data == HDR) begin
          in_frame = 1; pl.delete(); lastb = cyc;
        end
      end else if (rx_valid) begin
        lastb = cyc;
        if (rx_data == HDR) pl.delete();
        else if (rx_data[7]) begin
          e_err[cyc+1] = 1; in_frame = 0;
        end else if (pl.size() < NB) pl.push_back(rx_data[6:0]);
        else begin
          in_frame = 0;
          s = int'(rx_data[6:0]);
          foreach (pl[i]) s += int'(pl[i]);
          if (s % 128 != 0) e_err[cyc+1] = 1;
          else begin
            first = (cyc + 1 > free_at) ? cyc + 1 : free_at;
            for (int i = 0; i < NB; i++) begin
              e_we[first+i] = 1; e_addr[first+i] = 5'(i); e_data[first+i] = pl[i];
            end
            ld = first + NB;
            e_ld[ld] = 1;
            for (int k = cyc + 1; k <= ld + HOLD; k++) e_busy[k] = 1;
            acc = cyc;
            free_at = ld + HOLD;
          end
        end
      end else if (cyc - lastb == TMO) begin
        e_err[cyc+1] = 1; in_frame = 0;
      end
    end
  end

  int       we_rise[$], loads[$], runs[$];
  bit [6:0] cap [32];

  initial begin : compare
    int k; int cnt; int run; bit pwe; bit [4:0] la; bit [6:0] lda;
    cnt = 0; run = 0; pwe = 0; la = 0; lda = 0;
    forever begin
      @(negedge clk40);
      k = cyc + 1;
      if (rst) begin
        cnt = 0; run = 0; pwe = 0; la = 0; lda = 0;
        chk("rst_we", lut_we, 0);
        chk("rst_addr", lut_addr, 0);
        chk("rst_data", lut_data, 0);
        chk("rst_load", load_dacs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_errcnt", err_count, 0);
      end else begin
        if (e_err[k] && cnt < 255) cnt++;
        if (e_we[k]) begin la = e_addr[k]; lda = e_data[k]; end
        chk("lut_we", lut_we, e_we[k]);
        chk("lut_addr", lut_addr, la);
        chk("lut_data", lut_data, lda);
        chk("load_dacs", load_dacs, e_ld[k]);
        chk("busy", busy, e_busy[k]);
        chk("frame_err", frame_err, e_err[k]);
        chk("err_count", err_count, cnt);
        if (lut_we && !pwe) we_rise.push_back(k);
        if (lut_we) cap[lut_addr] = lut_data;
        pwe = lut_we;
        if (load_dacs) loads.push_back(k);
        if (busy) run++;
        else if (run > 0) begin runs.push_back(run); run = 0; end
      end
    end
  end

  logic [6:0] fr [NB];

  function automatic logic [6:0] csum_fr();
    int t = 0;
    foreach (fr[i]) t += int'(fr[i]);
    return 7'((128 - t % 128) % 128);
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk40);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk40);
  endtask

  task automatic send_frame(input logic [6:0] cx, input int maxgap);
    send(HDR);
    for (int i = 0; i < NB; i++) begin
      idle($urandom_range(maxgap, 0));
      send({1'b0, fr[i]});
    end
    idle($urandom_range(maxgap, 0));
    send({1'b0, csum_fr() ^ cx});
  endtask

  task automatic golden();
    foreach (fr[i]) fr[i] = 7'h00;
    fr[0] = 7'h23; fr[1] = 7'h02;
  endtask

  task automatic clr();
    we_rise.delete(); loads.delete(); runs.delete();
  endtask

  function automatic logic [7:0] junk();
    logic [7:0] b = 8'($urandom);
    return (b == HDR) ? 8'h3C : b;
  endfunction

  int t0, l1, e0, kind, found;

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // Golden frame
    golden();
    chk("golden_csum", csum_fr(), 'h5B);
    clr();
    send_frame(7'h00, 0);
    t0 = acc;
    idle(700);
    chk("g_nloads", loads.size(), 1);
    chk("g_we_lat", we_rise[0] - t0, 1);
    chk("g_load_lat", loads[0] - t0, 19);
    chk("g_busy_len", runs[0], 659);
    chk("g_addr0", cap[0], 'h23);
    chk("g_addr1", cap[1], 'h02);
    chk("g_addr17", cap[17], 'h00);

    // Bad checksum
    clr();
    send_frame(7'h01, 0);
    idle(30);
    chk("bad_nwe", we_rise.size(), 0);
    chk("bad_nload", loads.size(), 0);
    chk("bad_errcnt", err_count, 1);

    // Back-to-back: second checksum 100 cycles after the first strobe
    clr();
    send_frame(7'h00, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (loads.size() > 0) found = 1;
      else idle(1);
    end
    chk("b2b_first_load", found, 1);
    l1 = (loads.size() > 0) ? loads[0] : cyc;
    idle(l1 + 80 - cyc);
    send_frame(7'h00, 0);
    idle(800);
    chk("b2b_nloads", loads.size(), 2);
    chk("b2b_holdoff", we_rise[1] - l1, 640);
    chk("b2b_load2", loads[1] - we_rise[1], 18);

    // Mid-frame restart, then abort on a control byte
    clr();
    e0 = err_count;
    send(HDR);
    repeat (5) send(8'($urandom_range(127, 0)));
    send_frame(7'h00, 0);
    idle(700);
    chk("restart_err", err_count, e0);
    chk("restart_nloads", loads.size(), 1);
    send(HDR);
    repeat (3) send(8'($urandom_range(127, 0)));
    send(8'h81);
    idle(5);
    chk("abort_err", err_count, e0 + 1);

    // Timeout, byte exactly at expiry, then a normal frame
    send(HDR);
    repeat (4) send(8'h05);
    idle(TMO + 5);
    chk("tmo_err", err_count, e0 + 2);
    send(HDR);
    idle(TMO - 1);
    send(8'h11);
    idle(2);
    chk("tmo_edge_err", err_count, e0 + 2);
    clr();
    send_frame(7'h00, 0);
    idle(700);
    chk("tmo_nloads", loads.size(), 1);

    // Random traffic
    for (int it = 0; it < 25; it++) begin
      foreach (fr[i]) fr[i] = 7'($urandom);
      kind = $urandom_range(5, 0);
      case (kind)
        0: send_frame(7'h00, 2);
        1: send_frame(7'($urandom_range(127, 1)), 2);
        2: begin
          repeat ($urandom_range(4, 1)) send(junk());
          send_frame(7'h00, 1);
        end
        3: begin
          send(HDR);
          repeat ($urandom_range(17, 1)) send(8'($urandom_range(127, 0)));
          send_frame(7'h00, 1);
        end
        4: begin
          send(HDR);
          repeat ($urandom_range(10, 1)) send(8'($urandom_range(127, 0)));
          send(8'h80 | 8'($urandom_range(63, 0)));
        end
        default: begin
          send_frame(7'h00, 0);
          idle($urandom_range(25, 0));
          send(junk());
        end
      endcase
      idle($urandom_range(700, 0));
    end
    idle(700);

    // Error counter saturation
    repeat (260) begin
      send(HDR);
      send(8'h81);
      idle(1);
    end
    chk("sat_errcnt", err_count, 255);

    // Reset in the middle of a commit
    golden();
    send_frame(7'h00, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk40);
      if (lut_we && lut_addr == 5'd4) found = 1;
    end
    chk("rst_found_w5", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_now_we", lut_we, 0);
    chk("rst_now_load", load_dacs, 0);
    chk("rst_now_busy", busy, 0);
    @(negedge clk40);
    @(negedge clk40);
    #1 rst = 1'b0;
    @(negedge clk40);
    clr();
    send_frame(7'h00, 0);
    t0 = acc;
    idle(40);
    chk("post_rst_we_lat", we_rise[0] - t0, 1);
    chk("post_rst_load_lat", loads[0] - t0, 19);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
